// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with occupancy count and level flags; define SFIFO_ERR_EN for sticky overflow/underflow
module sync_fifo_lvl #(
   parameter int DSIZE    = 8,
   parameter int ASIZE    = 4,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
`ifdef SFIFO_ERR_EN
   input  logic             err_clr,
   output logic             overflow,
   output logic             underflow,
`endif
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             walmost_full,
   output logic             ralmost_empty,
   output logic [ASIZE:0]   count
);
   localparam logic [ASIZE:0] FULL = {1'b1, {ASIZE{1'b0}}};
   localparam logic [ASIZE:0] AF = AF_LEVEL[ASIZE:0];
   localparam logic [ASIZE:0] AE = AE_LEVEL[ASIZE:0];
   logic [DSIZE-1:0] mem_q [1<<ASIZE];
   logic [ASIZE:0] wptr_q, wptr_d, rptr_q, rptr_d, cnt_q, cnt_d;
   logic wfull_q, rempty_q, af_q, ae_q, wa, ra;
   // acceptance looks only at registered flags, so winc and rinc never gate each other
   always_comb begin
      wa = winc & ~wfull_q;
      ra = rinc & ~rempty_q;
      wptr_d = wptr_q + (ASIZE+1)'(wa);
      rptr_d = rptr_q + (ASIZE+1)'(ra);
      cnt_d = cnt_q + (ASIZE+1)'(wa) - (ASIZE+1)'(ra);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         wfull_q  <= cnt_d == FULL;
         rempty_q <= cnt_d == '0;
         af_q     <= cnt_d >= AF;
         ae_q     <= cnt_d <= AE;
      end
   always_ff @(posedge clk)
      if (wa) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
`ifdef SFIFO_ERR_EN
   logic ovf_q, ovf_d, unf_q, unf_d;
   // a new error event on the clearing edge wins over err_clr
   always_comb begin
      ovf_d = (winc & wfull_q) | (ovf_q & ~err_clr);
      unf_d = (rinc & rempty_q) | (unf_q & ~err_clr);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif
   assign rdata         = mem_q[rptr_q[ASIZE-1:0]];
   assign wfull         = wfull_q;
   assign rempty        = rempty_q;
   assign walmost_full  = af_q;
   assign ralmost_empty = ae_q;
   assign count         = cnt_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: directed and random traffic checked against a queue model of the FIFO
module tb_sync_fifo_lvl;
   logic clk = 1'b0, rst_n = 1'b0, winc = 1'b0, rinc = 1'b0, err_clr = 1'b0;
   logic [7:0] wdata = '0, rdata;
   logic wfull, rempty, walmost_full, ralmost_empty;
   logic [4:0] count;
`ifdef SFIFO_ERR_EN
   logic overflow, underflow;
`endif
   bit [7:0] q[$];
   bit m_ovf, m_unf;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   sync_fifo_lvl dut (
      .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata), .rinc(rinc),
`ifdef SFIFO_ERR_EN
      .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
      .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
      .ralmost_empty(ralmost_empty), .count(count)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all();
      chk("count", 32'(count), q.size());
      chk("rempty", rempty, q.size() == 0);
      chk("wfull", wfull, q.size() == 16);
      chk("ralmost_empty", ralmost_empty, q.size() <= 2);
      chk("walmost_full", walmost_full, q.size() >= 12);
      if (q.size() != 0) chk("rdata", rdata, q[0]);
`ifdef SFIFO_ERR_EN
      chk("overflow", overflow, m_ovf);
      chk("underflow", underflow, m_unf);
`endif
   endtask
   // drive one cycle, advance the model with pre-edge occupancy, then check after the edge
   task automatic step(input logic w, input logic [7:0] d, input logic r);
      bit full, empty;
      winc = w;
      wdata = d;
      rinc = r;
      full = q.size() == 16;
      empty = q.size() == 0;
      @(posedge clk);
      m_ovf = (w && full) || (m_ovf && !err_clr);
      m_unf = (r && empty) || (m_unf && !err_clr);
      if (r && !empty) void'(q.pop_front());
      if (w && !full) q.push_back(d);
      #1;
      check_all();
   endtask
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      #12;
      check_all();
      chk("reset_rempty", rempty, 1'b1);
      rst_n = 1'b1;
      for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
      chk("fill_wfull", wfull, 1'b1);
      chk("fill_rdata", rdata, 8'h01);
      for (int i = 1; i <= 16; i++) begin
         chk("drain_rdata", rdata, 8'(i));
         step(1'b0, 8'h00, 1'b1);
      end
      chk("drain_rempty", rempty, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);
      chk("wrap_count", 32'(count), 5);
      for (int i = 0; i < 11; i++) step(1'b1, 8'($urandom), 1'b0);
      chk("full_wfull", wfull, 1'b1);
      step(1'b1, 8'hAA, 1'b1);
      chk("full_rw_count", 32'(count), 15);
      chk("full_rw_wfull", wfull, 1'b0);
`ifdef SFIFO_ERR_EN
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h55, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      err_clr = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
      chk("ovf_clr", overflow, 1'b0);
`endif
      for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h3C, 1'b1);
      chk("empty_rw_count", 32'(count), 1);
      chk("empty_rw_rdata", rdata, 8'h3C);
      step(1'b0, 8'h00, 1'b1);
`ifdef SFIFO_ERR_EN
      step(1'b0, 8'h00, 1'b1);
      chk("unf_set", underflow, 1'b1);
      step(1'b1, 8'h77, 1'b0);
      chk("unf_rptr_held", rdata, 8'h77);
      err_clr = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      err_clr = 1'b0;
      chk("unf_clr", underflow, 1'b0);
`endif
      for (int i = 0; i < 400; i++) begin
         int bias;
         bias = ((i / 100) % 2) ? 70 : 30;
         err_clr = $urandom_range(0, 7) == 0;
         step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < 100 - bias);
      end
      err_clr = 1'b0;
      for (int i = 0; i < 20 && q.size() < 7; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 20 && q.size() > 7; i++) step(1'b0, 8'h00, 1'b1);
      chk("pre_rst_count", 32'(count), 7);
      winc = 1'b1;
      wdata = 8'hE5;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(count), 0);
      chk("arst_rempty", rempty, 1'b1);
      chk("arst_wfull", wfull, 1'b0);
      chk("arst_ae", ralmost_empty, 1'b1);
      chk("arst_af", walmost_full, 1'b0);
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      winc = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
- Single-clock, parametrised successor to the team's dual-clock FIFO, for blocks where producer and consumer share one clock.
- Drops the pointer synchronisers and Gray coding.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, and same-cycle read+write at full and empty boundaries.
- Storage is an internal register array with show-ahead (combinational) read, the same read style as the existing FIFO memory.

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 4, address width; depth = 2**ASIZE entries.
- AF_LEVEL, 12, walmost_full asserts when count >= AF_LEVEL; legal range 1..2**ASIZE.
- AE_LEVEL, 2, ralmost_empty asserts when count <= AE_LEVEL; must satisfy AE_LEVEL < AF_LEVEL.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- winc  input  1  write request.
- wdata  input  DSIZE  write data.
- rinc  input  1  read request (pop).
- rdata  output  DSIZE  head-of-FIFO data, show-ahead.
- wfull  output  1  FIFO full.
- rempty  output  1  FIFO empty.
- walmost_full  output  1  count >= AF_LEVEL.
- ralmost_empty  output  1  count <= AE_LEVEL.
- count  output  ASIZE+1  current occupancy, 0..2**ASIZE.
- err_clr  input  1  clears sticky error flags (present only with SFIFO_ERR_EN).
- overflow  output  1  sticky: write attempted while full (present only with SFIFO_ERR_EN).
- underflow  output  1  sticky: read attempted while empty (present only with SFIFO_ERR_EN).

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: wptr = rptr = 0, count = 0, rempty = 1, wfull = 0, ralmost_empty = 1, walmost_full = 0, overflow = underflow = 0. Memory contents are not reset. rdata is don't-care while rempty = 1.
- Pointers are ASIZE+1-bit binary. Address = low ASIZE bits. The extra MSB distinguishes full from empty on wrap-around.
- Write accept: wa = winc & !wfull. On the clk edge, mem[waddr] <= wdata and wptr increments. wptr wraps naturally modulo 2**(ASIZE+1).
- Read accept: ra = rinc & !rempty. On the clk edge, rptr increments.
- Acceptance uses the registered flags only. There is no combinational path from rinc to write acceptance or from winc to read acceptance.
  - Full, winc and rinc both high: read accepted, write dropped (counts as overflow).
  - Empty, winc and rinc both high: write accepted, read dropped (counts as underflow).
  - Not full and not empty: both accepted, count unchanged.
- Next count = count + wa - ra.
- All flags are registered and computed from next-state values on the same edge, so they are valid the cycle after the causing access:
  - rempty = (next count == 0)
  - wfull = (next count == 2**ASIZE)
  - ralmost_empty = (next count <= AE_LEVEL)
  - walmost_full = (next count >= AF_LEVEL)
- Read data: rdata = mem[raddr], combinational. The head word is valid whenever rempty = 0.
- Latency: a word written at edge N is visible on rdata with rempty = 0 after edge N.
- Overwrite protection: a full FIFO never overwrites unread data. An empty FIFO never advances rptr.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any stored data is lost.

Optional Feature:
- Macro: SFIFO_ERR_EN.
- Defined:
  - Adds ports err_clr, overflow, underflow.
  - overflow sets on any edge where winc & wfull; underflow sets on any edge where rinc & rempty.
  - Both flags hold until err_clr = 1. err_clr clears them on that edge; a set event on the same edge wins over the clear.
  - Reset value 0.
- Not defined: the ports and logic are absent. Dropped accesses are silently ignored.

Test Plan:
- Reset, then write 0x01..0x10 with ASIZE = 4 -> count 16, wfull = 1 after the 16th edge; walmost_full = 1 once count reaches 12; rdata = 0x01.
- Read 16 words from full -> rdata sequence 0x01..0x10; rempty = 1 after the last edge; ralmost_empty = 1 once count <= 2.
- With count = 5, hold winc = rinc = 1 for 40 cycles (pointer wrap) -> count stays 5, data order preserved, no flag toggles.
- Full, winc = rinc = 1 -> count 15, wfull = 0, wdata not stored. Empty, winc = rinc = 1 -> count 1, rdata = wdata next cycle.
- With SFIFO_ERR_EN: write while full -> overflow = 1; then err_clr = 1 -> overflow = 0 next cycle. Read while empty -> underflow = 1, and rptr unchanged.
- Assert rst_n = 0 asynchronously mid-burst with count = 7 -> count = 0, rempty = 1, wfull = 0 immediately, before the next clk edge.
